// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS32 boot loader: FSM state encodings and the
// opcode constants of the instructions the loader's test programs use.
package mips_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_DUMP  = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_BEQZ = 6'b001110;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/mips_boot_loader_if.sv
// Bundle of every loader-facing signal: host program stream, instruction-memory
// write port, core control, register-file read port and the register dump stream.
interface mips_boot_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RF_AW  = 5
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_hold;
  logic              core_clr;
  logic              core_halted;
  logic [RF_AW-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [RF_AW-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              done;
  logic              err_ovf;
  logic              err_tmo;

  // The loader itself.
  modport master (
    input  start, in_valid, in_data, in_last, core_halted, rf_rdata, dump_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, core_hold, core_clr,
           rf_raddr, dump_valid, dump_idx, dump_data, done, err_ovf, err_tmo
  );

  // Host, memory, core and dump consumer seen together.
  modport slave (
    output start, in_valid, in_data, in_last, core_halted, rf_rdata, dump_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, core_clr,
           rf_raddr, dump_valid, dump_idx, dump_data, done, err_ovf, err_tmo
  );

endinterface

// File: rtl/mips_boot_loader_timer.sv
// RUN-phase watchdog: cleared by load, counts while enabled, flags the last
// permitted cycle (count == TIMEOUT-1).
module mips_boot_loader_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT_CNT  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SAT_CNT)) begin
      // Saturate so a lingering enable can never wrap back into range.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mips_boot_loader.sv
// Program loader / run controller for the MIPS32 core: streams a program into
// instruction memory, runs the core until HLT or timeout, then dumps registers.
module mips_boot_loader
  import mips_boot_loader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int RF_AW     = 5,
  parameter int DUMP_REGS = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips_boot_loader_if.master  bus
);

  localparam logic [ADDR_W-1:0] MAX_PTR  = '1;
  localparam logic [RF_AW-1:0]  LAST_IDX = RF_AW'(DUMP_REGS - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RF_AW-1:0]  idx_q, idx_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;

  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_tc;
  logic [DATA_W-1:0] rf_word;

  assign rf_word = bus.rf_rdata;

  mips_boot_loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk1  (clk1),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      idx_q     <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      idx_q     <= idx_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    idx_d     = idx_q;
    err_ovf_d = err_ovf_q;
    err_tmo_d = err_tmo_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    bus.in_ready   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.core_hold  = 1'b1;
    bus.core_clr   = 1'b0;
    bus.rf_raddr   = '0;
    bus.dump_valid = 1'b0;
    bus.dump_idx   = '0;
    bus.dump_data  = '0;
    bus.done       = 1'b0;
    bus.err_ovf    = err_ovf_q;
    bus.err_tmo    = err_tmo_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        bus.done = (state_q == ST_DONE);
        if (bus.start) begin
          state_d   = ST_LOAD;
          wr_ptr_d  = '0;
          err_ovf_d = 1'b0;
          err_tmo_d = 1'b0;
        end
      end

      ST_LOAD: begin
        bus.in_ready  = 1'b1;
        bus.mem_we    = bus.in_valid;
        bus.mem_addr  = wr_ptr_q;
        bus.mem_wdata = bus.in_data;
        if (bus.in_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (bus.in_last) begin
            state_d = ST_CLEAR;
          end else if (wr_ptr_q == MAX_PTR) begin
            // Memory full and the program is still coming: never release the core.
            err_ovf_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_CLEAR: begin
        bus.core_clr = 1'b1;
        tmr_load     = 1'b1;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        bus.core_hold = 1'b0;
        tmr_en        = 1'b1;
        // A halt seen on the terminal-count cycle is a clean finish, not a timeout.
        if (bus.core_halted) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end else if (tmr_tc) begin
          err_tmo_d = 1'b1;
          state_d   = ST_DUMP;
          idx_d     = '0;
        end
      end

      ST_DUMP: begin
        bus.rf_raddr   = idx_q;
        bus.dump_valid = 1'b1;
        bus.dump_idx   = idx_q;
        bus.dump_data  = rf_word;
        if (bus.dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: behavioural core/memory model,
// write and dump scoreboards, table vectors for idle/done states.
module tb_mips_boot_loader;
  import mips_boot_loader_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RW = 5;
  localparam int NREGS = 6;
  localparam int TMO = 64;

  logic clk1;
  logic rst_n;

  mips_boot_loader_if #(.DATA_W(DW), .ADDR_W(AW), .RF_AW(RW)) bus ();

  mips_boot_loader #(
    .DATA_W(DW), .ADDR_W(AW), .RF_AW(RW), .DUMP_REGS(NREGS), .TIMEOUT(TMO)
  ) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Core + instruction memory model
  logic [DW-1:0] imem [16];
  logic [DW-1:0] regs [32];
  logic [AW-1:0] pc;
  logic          halted;
  logic [DW-1:0] ir;

  assign ir              = imem[pc];
  assign bus.core_halted = halted;
  assign bus.rf_rdata    = regs[bus.rf_raddr];

  always @(posedge clk1) begin
    if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
  end

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.core_clr) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!bus.core_hold && !halted) begin
      pc <= pc + 4'd1;
      case (opcode_of(ir))
        OP_ADDI: regs[ir[20:16]] <= regs[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
        OP_ADD:  regs[ir[15:11]] <= regs[ir[25:21]] + regs[ir[20:16]];
        OP_OR:   regs[ir[15:11]] <= regs[ir[25:21]] | regs[ir[20:16]];
        OP_BEQZ: if (regs[ir[25:21]] == '0) pc <= pc + 4'd1 + ir[3:0];
        OP_HLT:  halted <= 1'b1;
        default: ;
      endcase
    end
  end

  // Scoreboards and counters
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [RW-1:0] idx;  logic [DW-1:0] data; } dump_t;
  typedef struct {
    logic in_valid; logic in_last; logic dump_ready; logic [DW-1:0] data;
    logic exp_in_ready; logic exp_mem_we; logic exp_hold; logic exp_done;
  } vec_t;

  wr_t   exp_wr[$];
  dump_t exp_dump[$];
  vec_t  vecs[8];

  int pass_cnt;
  int total_cnt;
  int run_cycles;
  int clr_pulses;
  int tb_ptr;
  logic          prev_stall;
  logic [RW-1:0] prev_idx;
  logic [DW-1:0] prev_data;

  logic [DW-1:0] prog[$];
  logic [DW-1:0] ovf_prog[$];
  logic [DW-1:0] loop_prog[$];
  int            exp_regs[NREGS];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return bus.core_clr;
      1:       return bus.dump_valid;
      default: return bus.done;
    endcase
  endfunction

  task automatic monitor();
    wr_t   w;
    dump_t d;
    if (bus.mem_we) begin
      check("wr_expected", 64'(exp_wr.size() != 0), 64'(1));
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(w.data));
      end
    end
    if (prev_stall) begin
      check("stall_valid", 64'(bus.dump_valid), 64'(1));
      check("stall_idx", 64'(bus.dump_idx), 64'(prev_idx));
      check("stall_data", 64'(bus.dump_data), 64'(prev_data));
    end
    if (bus.dump_valid && bus.dump_ready) begin
      check("dump_expected", 64'(exp_dump.size() != 0), 64'(1));
      if (exp_dump.size() != 0) begin
        d = exp_dump.pop_front();
        check("dump_idx", 64'(bus.dump_idx), 64'(d.idx));
        check("dump_data", 64'(bus.dump_data), 64'(d.data));
        $display("dump R%0d = %0d", bus.dump_idx, bus.dump_data);
      end
    end
    prev_stall = bus.dump_valid && !bus.dump_ready;
    prev_idx   = bus.dump_idx;
    prev_data  = bus.dump_data;
    if (!bus.core_hold) run_cycles++;
    if (bus.core_clr) clr_pulses++;
  endtask

  task automatic cycle();
    @(negedge clk1);
    monitor();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_for(input string name, input int sel, input int budget);
    int n;
    n = 0;
    while (!sig_sel(sel) && n < budget) begin
      cycle();
      n++;
    end
    check(name, 64'(sig_sel(sel)), 64'(1));
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic send_words(input logic [DW-1:0] w[$], input bit with_last, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      bus.in_last  = with_last && (i == hi);
      #1;
      check("load_ready", 64'(bus.in_ready), 64'(1));
      exp_wr.push_back('{addr: AW'(tb_ptr), data: w[i]});
      $display("load word %0d addr %0d data %08h", i, tb_ptr, w[i]);
      tb_ptr++;
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < NREGS; i++) exp_dump.push_back('{idx: RW'(i), data: DW'(exp_regs[i])});
  endtask

  task automatic drain(input bit stall);
    int k;
    k = 0;
    while (!bus.done && k < 200) begin
      bus.dump_ready = stall ? (k % 4 == 3) : 1'b1;
      cycle();
      k++;
    end
    bus.dump_ready = 1'b0;
    check("dump_finished", 64'(bus.done), 64'(1));
    check("dump_all_seen", 64'(exp_dump.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"},   64'(bus.core_hold),  64'(1));
    check({tag, "_ready"},  64'(bus.in_ready),   64'(0));
    check({tag, "_we"},     64'(bus.mem_we),     64'(0));
    check({tag, "_addr"},   64'(bus.mem_addr),   64'(0));
    check({tag, "_clr"},    64'(bus.core_clr),   64'(0));
    check({tag, "_raddr"},  64'(bus.rf_raddr),   64'(0));
    check({tag, "_dvalid"}, 64'(bus.dump_valid), 64'(0));
    check({tag, "_ddata"},  64'(bus.dump_data),  64'(0));
    check({tag, "_done"},   64'(bus.done),       64'(0));
    check({tag, "_ovf"},    64'(bus.err_ovf),    64'(0));
    check({tag, "_tmo"},    64'(bus.err_tmo),    64'(0));
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.in_valid   = vecs[i].in_valid;
      bus.in_last    = vecs[i].in_last;
      bus.dump_ready = vecs[i].dump_ready;
      bus.in_data    = vecs[i].data;
      #1;
      $display("vec %0d in_valid=%0b in_ready=%0b mem_we=%0b hold=%0b done=%0b",
               i, bus.in_valid, bus.in_ready, bus.mem_we, bus.core_hold, bus.done);
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready),  64'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d_mem_we", i),   64'(bus.mem_we),    64'(vecs[i].exp_mem_we));
      check($sformatf("vec%0d_hold", i),     64'(bus.core_hold), 64'(vecs[i].exp_hold));
      check($sformatf("vec%0d_done", i),     64'(bus.done),      64'(vecs[i].exp_done));
      cycle();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.dump_ready = 1'b0; bus.in_data = '0;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; run_cycles = 0; clr_pulses = 0; tb_ptr = 0;
    prev_stall = 1'b0; prev_idx = '0; prev_data = '0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.dump_ready = 1'b0;

    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    for (int i = 0; i < 16; i++) ovf_prog.push_back(32'hab000000 + i);
    loop_prog = '{32'h3800ffff};
    exp_regs = '{0, 10, 20, 25, 30, 55};
    //          in_valid last rdy  data          ready we  hold done
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h66666666, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    apply_vecs(0, 3);

    // Normal program: load, run to HLT, dump R0..R5
    start_pulse();
    tb_ptr = 0;
    check("load_entered", 64'(bus.in_ready), 64'(1));
    send_words(prog, 1'b0, 0, 3);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("start_in_load_ignored", 64'(bus.in_ready), 64'(1));
    send_words(prog, 1'b1, 4, 8);
    check("all_words_written", 64'(exp_wr.size()), 64'(0));
    check("clr_pulse", 64'(bus.core_clr), 64'(1));
    check("clr_hold", 64'(bus.core_hold), 64'(1));
    run_cycles = 0;
    push_dump();
    cycle();
    check("clr_one_cycle", 64'(bus.core_clr), 64'(0));
    check("run_released", 64'(bus.core_hold), 64'(0));
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("start_in_run_ignored", 64'(bus.in_ready), 64'(0));
    wait_for("wait_dump_prog", 1, 100);
    check("prog_run_cycles", 64'(run_cycles), 64'(10));
    check("dump_hold", 64'(bus.core_hold), 64'(1));
    drain(1'b0);
    check("prog_ovf", 64'(bus.err_ovf), 64'(0));
    check("prog_tmo", 64'(bus.err_tmo), 64'(0));
    apply_vecs(4, 7);

    // Overflow: fill the whole memory without in_last
    start_pulse();
    tb_ptr = 0;
    clr_pulses = 0;
    send_words(ovf_prog, 1'b0, 0, 15);
    check("ovf_flag", 64'(bus.err_ovf), 64'(1));
    check("ovf_done", 64'(bus.done), 64'(1));
    check("ovf_hold", 64'(bus.core_hold), 64'(1));
    check("ovf_ready", 64'(bus.in_ready), 64'(0));
    cycle(); cycle();
    check("ovf_no_clr", 64'(clr_pulses), 64'(0));
    check("ovf_sticky", 64'(bus.err_ovf), 64'(1));

    // Timeout: self-branch, dump with 3-cycle stalls per word
    start_pulse();
    tb_ptr = 0;
    check("restart_clears_ovf", 64'(bus.err_ovf), 64'(0));
    check("restart_not_done", 64'(bus.done), 64'(0));
    send_words(loop_prog, 1'b1, 0, 0);
    check("tmo_clr", 64'(bus.core_clr), 64'(1));
    run_cycles = 0;
    push_dump();
    cycle();
    wait_for("wait_dump_tmo", 1, 200);
    check("tmo_flag", 64'(bus.err_tmo), 64'(1));
    check("tmo_run_cycles", 64'(run_cycles), 64'(TMO));
    drain(1'b1);
    check("tmo_sticky", 64'(bus.err_tmo), 64'(1));

    // Reset in the middle of RUN, then a clean rerun
    start_pulse();
    tb_ptr = 0;
    check("restart_clears_tmo", 64'(bus.err_tmo), 64'(0));
    send_words(prog, 1'b1, 0, 8);
    check("rr_clr", 64'(bus.core_clr), 64'(1));
    cycle(); cycle(); cycle(); cycle();
    check("rr_in_run", 64'(bus.core_hold), 64'(0));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    check("post_reset_idle_ready", 64'(bus.in_ready), 64'(0));
    check("post_reset_idle_hold", 64'(bus.core_hold), 64'(1));
    start_pulse();
    tb_ptr = 0;
    send_words(prog, 1'b1, 0, 8);
    check("rerun_clr", 64'(bus.core_clr), 64'(1));
    run_cycles = 0;
    push_dump();
    cycle();
    wait_for("wait_dump_rerun", 1, 100);
    check("rerun_run_cycles", 64'(run_cycles), 64'(10));
    drain(1'b0);
    check("rerun_no_err", 64'({bus.err_ovf, bus.err_tmo}), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
